uart_rx_oversampled: RTL and testbench

- Serial receive stage that sits directly upstream of the operand/opcode sequencing block.
- Deserialises 8N1 UART frames from the `rx` pin using 16x oversampling with an internal baud-tick divider.
- Presents each received byte on `d_out` with a level-style `rx_done` flag, which the downstream block samples across several of its states.

---
 rtl/uart_rx_oversampled.sv | 153 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampled
//   8N1 UART receiver with 16x oversampling. A free-running divider produces
//   one oversample tick every BAUD_DIV clocks. The FSM waits 8 ticks from the
//   detected falling edge to reach the middle of the start bit, then takes one
//   sample every 16 ticks. Each received byte is held on d_out with a level
//   rx_done flag until the next start bit begins.
//
// Parameters
//   DBIT     data bits per frame, LSB first (2 or more)
//   SB_TICK  oversample ticks spanned by the stop bit
//   BAUD_DIV clk cycles per oversample tick (2 or more)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   rx        serial line, idles high, asynchronous to clk
//   d_out     last correctly framed byte
//   rx_done   byte valid (level, cleared by the next start bit)
//   frame_err last frame had a low stop bit
// ---------------------------------------------------------------------------
module uart_rx_oversampled #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 163
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] d_out,
  output logic            rx_done,
  output logic            frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(7);
  localparam logic [SW-1:0] S_LAST    = SW'(15);
  localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            rx_s;
  logic [CW-1:0]   baud_cnt;
  logic            tick;
  logic [SW-1:0]   s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] shift;

  // Two-flop synchroniser, preset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

  // Free-running oversample divider; the FSM never restarts it, so sampling
  // points carry up to one tick of phase jitter against the start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 baud_cnt <= '0;
    else if (baud_cnt == BAUD_LAST) baud_cnt <= '0;
    else                        baud_cnt <= baud_cnt + 1'b1;
  end
  assign tick = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      shift     <= '0;
      d_out     <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Edge detection runs every clk, not on ticks, to keep the
          // start-bit phase error within one tick.
          if (!rx_s) begin
            state     <= START;
            s_cnt     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state <= IDLE;  // glitch shorter than half a bit
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == S_LAST) begin
              shift <= {rx_s, shift[DBIT-1:1]};
              s_cnt <= '0;
              if (n_cnt == N_LAST) state <= STOP;
              else                 n_cnt <= n_cnt + 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == S_STOP) begin
              if (rx_s) begin
                d_out     <= shift;
                rx_done   <= 1'b1;
                frame_err <= 1'b0;
                state     <= IDLE;
              end else begin
                // Keep the previous good byte; park until the line recovers
                // so a held-low break cannot be read as endless 0x00 frames.
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

  localparam int BAUD_DIV = 4;
  localparam int BIT      = 16 * BAUD_DIV;  // 64 clk per bit

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] d_out;
  logic       rx_done;
  logic       frame_err;

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BAUD_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .d_out     (d_out),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;   // 1: expect frame_err rise, 0: expect rx_done rise
    logic [7:0] data;  // expected d_out at that event
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic done_at_start;
  logic done_after3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one frame starting on a negedge; records rx_done just before the
  // start bit and 3 clk into it.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    done_at_start = rx_done;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    done_after3 = rx_done;
    repeat (BIT - 3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_val;
    repeat (BIT) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every rx_done / frame_err rising edge.
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;
  logic [7:0] held      = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (rx_done && !prev_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_rx_done actual=%0h required=none", d_out);
        end else begin
          e = sb.pop_front();
          chk("done_kind", {31'd0, e.err}, 32'd0);
          chk("done_data", {24'd0, d_out}, {24'd0, e.data});
          chk("done_frame_err", {31'd0, frame_err}, 32'd0);
          held = e.data;
        end
      end
      if (frame_err && !prev_err) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_frame_err actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("err_kind", {31'd0, e.err}, 32'd1);
          chk("err_data_kept", {24'd0, d_out}, {24'd0, e.data});
          chk("err_no_done", {31'd0, rx_done}, 32'd0);
        end
      end
      if (!rx_done && prev_done)
        chk("d_out_stable", {24'd0, d_out}, {24'd0, held});
    end
    prev_done = rx_done;
    prev_err  = frame_err;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_d_out", {24'd0, d_out}, 32'd0);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    // Basic frame 0x5A, flag must stay up while idle
    sb.push_back('{err: 1'b0, data: 8'h5A});
    send_frame(8'h5A, 1'b1);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("5a_held_done", {31'd0, rx_done}, 32'd1);
    chk("5a_held_data", {24'd0, d_out}, 32'h5A);

    // Back-to-back extremes, single stop bit
    sb.push_back('{err: 1'b0, data: 8'h00});
    sb.push_back('{err: 1'b0, data: 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    chk("b2b_done_before_edge", {31'd0, done_at_start}, 32'd1);
    chk("b2b_done_drop_3clk", {31'd0, done_after3}, 32'd0);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);

    // False start: 12 clk glitch
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_rx_done", {31'd0, rx_done}, 32'd0);
    chk("glitch_d_out", {24'd0, d_out}, 32'hFF);
    sb.push_back('{err: 1'b0, data: 8'h3C});
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);

    // Framing error, line held low 5 bit periods from the stop bit
    sb.push_back('{err: 1'b1, data: 8'h3C});
    send_frame(8'hA5, 1'b0);
    repeat (4 * BIT) @(negedge clk);
    chk("break_frame_err", {31'd0, frame_err}, 32'd1);
    chk("break_rx_done", {31'd0, rx_done}, 32'd0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    sb.push_back('{err: 1'b0, data: 8'h11});
    send_frame(8'h11, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);

    // Reset in the middle of data bit 4 of 0xC3
    begin
      logic [7:0] c3;
      c3 = 8'hC3;
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rx = c3[i];
        repeat (BIT) @(negedge clk);
      end
      rx = c3[4];
      repeat (BIT / 2) @(negedge clk);
    end
    chk("pre_reset_d_out", {24'd0, d_out}, 32'h11);
    reset = 1'b0;
    #1;
    chk("async_reset_d_out", {24'd0, d_out}, 32'd0);
    chk("async_reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("async_reset_frame_err", {31'd0, frame_err}, 32'd0);
    repeat (2) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    sb.push_back('{err: 1'b0, data: 8'h7E});
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("final_rx_done", {31'd0, rx_done}, 32'd1);
    chk("final_d_out", {24'd0, d_out}, 32'h7E);

    // All expected events must have been observed
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
